// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - shared types and constants for the FOC loop sequencer
`timescale 1ns/1ps
package foc_pkg;

  localparam int D_WIDTH_DEF = 19;
  localparam int Q_BITS_DEF  = 15;

  // PID coefficient register addresses inside each axis controller
  localparam int PID_KP_ADDR = 0;
  localparam int PID_KI_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    ISSUE = 2'd2,
    BUSY  = 2'd3
  } state_t;

endpackage

// File: rtl/loop_timer.sv
// rtl/loop_timer.sv - free-running period counter producing the loop tick
`timescale 1ns/1ps
module loop_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period_in,
  output logic                 tick
);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] period_eff;
  logic [CNT_WIDTH-1:0] period_cur;

  assign period_eff = (period_in < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period_in;
  // The period is latched at count 0, so use the live input on that cycle only
  assign period_cur = (count == '0) ? period_eff : period_q;
  assign tick       = enable && (count == period_cur - CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      count    <= '0;
      period_q <= '0;
    end else if (!enable) begin
      count    <= '0;
    end else begin
      if (count == '0) begin
        period_q <= period_eff;
      end
      count <= tick ? '0 : count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/foc_loop_sched.sv
// rtl/foc_loop_sched.sv - FOC current-loop sequencer: trigger, sample hold, core handshake, PID config arbitration
`timescale 1ns/1ps
module foc_loop_sched
  import foc_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int Q_BITS    = Q_BITS_DEF,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic [D_WIDTH-1:0]   angle_adc,
  input  logic [D_WIDTH-1:0]   currA_adc,
  input  logic [D_WIDTH-1:0]   currB_adc,
  input  logic [D_WIDTH-1:0]   currC_adc,
  input  logic [D_WIDTH-1:0]   currT_req,
  output logic [D_WIDTH-1:0]   angle_out,
  output logic [D_WIDTH-1:0]   currA_out,
  output logic [D_WIDTH-1:0]   currB_out,
  output logic [D_WIDTH-1:0]   currC_out,
  output logic [D_WIDTH-1:0]   currT_out,
  output logic                 core_valid,
  input  logic                 core_ready,
  input  logic                 cfg_req,
  input  logic                 cfg_sel,
  input  logic [D_WIDTH-1:0]   cfg_addr,
  input  logic [D_WIDTH-1:0]   cfg_data,
  output logic                 cfg_ack,
  output logic                 pid_d_wen,
  output logic                 pid_q_wen,
  output logic [D_WIDTH-1:0]   pid_d_addr,
  output logic [D_WIDTH-1:0]   pid_q_addr,
  output logic [D_WIDTH-1:0]   pid_d_data,
  output logic [D_WIDTH-1:0]   pid_q_data,
  input  logic                 clear_err,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] loop_count
);

  localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

  if (Q_BITS >= D_WIDTH) begin : g_q_bits_check
    $error("Q_BITS must be smaller than D_WIDTH");
  end

  state_t              state;
  state_t              state_next;
  logic                tick;
  logic                pending_tick;
  logic [WD_WIDTH-1:0] watchdog;

  logic capture;
  logic cfg_go;
  logic loop_done;
  logic timeout_evt;
  logic tick_in_loop;
  logic overrun_evt;

  loop_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_loop_timer (
    .clk       (clk),
    .rstb      (rstb),
    .enable    (enable),
    .period_in (period_in),
    .tick      (tick)
  );

  always_comb begin
    state_next  = state;
    timeout_evt = 1'b0;
    loop_done   = 1'b0;
    case (state)
      IDLE: begin
        // Loop triggers always win over host configuration
        if (tick || pending_tick) begin
          state_next = ISSUE;
        end else if (cfg_req) begin
          state_next = CFG;
        end
      end
      CFG:   state_next = IDLE;
      ISSUE: state_next = BUSY;
      BUSY: begin
        if (core_ready) begin
          loop_done  = 1'b1;
          state_next = IDLE;
        end else if (watchdog == WD_WIDTH'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture      = (state == IDLE) && (state_next == ISSUE);
  assign cfg_go       = (state == IDLE) && (state_next == CFG);
  assign tick_in_loop = tick && (state != IDLE);
  assign overrun_evt  = tick_in_loop && pending_tick;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pending_tick <= 1'b0;
      watchdog     <= '0;
      loop_count   <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (capture) begin
        pending_tick <= 1'b0;
      end else if (tick_in_loop) begin
        pending_tick <= 1'b1;
      end

      if (state == ISSUE) begin
        watchdog <= '0;
      end else if ((state == BUSY) && !core_ready) begin
        watchdog <= watchdog + WD_WIDTH'(1);
      end

      if (loop_done) begin
        loop_count <= loop_count + CNT_WIDTH'(1);
      end

      // A set event in the same cycle as clear_err takes precedence
      if (overrun_evt) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      angle_out <= '0;
      currA_out <= '0;
      currB_out <= '0;
      currC_out <= '0;
      currT_out <= '0;
    end else if (capture) begin
      angle_out <= angle_adc;
      currA_out <= currA_adc;
      currB_out <= currB_adc;
      currC_out <= currC_adc;
      currT_out <= currT_req;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      core_valid <= 1'b0;
      cfg_ack    <= 1'b0;
      pid_d_wen  <= 1'b0;
      pid_q_wen  <= 1'b0;
      pid_d_addr <= '0;
      pid_q_addr <= '0;
      pid_d_data <= '0;
      pid_q_data <= '0;
    end else begin
      core_valid <= capture;
      cfg_ack    <= cfg_go;
      pid_d_wen  <= cfg_go && !cfg_sel;
      pid_q_wen  <= cfg_go && cfg_sel;
      pid_d_addr <= (cfg_go && !cfg_sel) ? cfg_addr : '0;
      pid_d_data <= (cfg_go && !cfg_sel) ? cfg_data : '0;
      pid_q_addr <= (cfg_go && cfg_sel) ? cfg_addr : '0;
      pid_q_data <= (cfg_go && cfg_sel) ? cfg_data : '0;
    end
  end

endmodule

// File: tb/tb_foc_loop_sched.sv
// tb/tb_foc_loop_sched.sv - directed self-checking bench for foc_loop_sched
`timescale 1ns/1ps
module tb_foc_loop_sched;
  import foc_pkg::*;

  localparam int DW = 19;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstb;
  logic          enable;
  logic [CW-1:0] period_in;
  logic [DW-1:0] angle_adc, currA_adc, currB_adc, currC_adc, currT_req;
  logic [DW-1:0] angle_out, currA_out, currB_out, currC_out, currT_out;
  logic          core_valid, core_ready;
  logic          cfg_req, cfg_sel, cfg_ack;
  logic [DW-1:0] cfg_addr, cfg_data;
  logic          pid_d_wen, pid_q_wen;
  logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
  logic          clear_err, overrun, timeout_err;
  logic [CW-1:0] loop_count;

  int checks = 0;
  int errors = 0;
  int exp_loops = 0;

  always #5 clk = ~clk;

  foc_loop_sched #(
    .D_WIDTH(DW), .Q_BITS(15), .CNT_WIDTH(CW), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .period_in(period_in),
    .angle_adc(angle_adc), .currA_adc(currA_adc), .currB_adc(currB_adc),
    .currC_adc(currC_adc), .currT_req(currT_req),
    .angle_out(angle_out), .currA_out(currA_out), .currB_out(currB_out),
    .currC_out(currC_out), .currT_out(currT_out),
    .core_valid(core_valid), .core_ready(core_ready),
    .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
    .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
    .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
    .clear_err(clear_err), .overrun(overrun), .timeout_err(timeout_err),
    .loop_count(loop_count)
  );

  function automatic logic [DW-1:0] samp(input int k, input int ch);
    if (ch == 4) return DW'(-(k * 100));
    return DW'(k * 4096 + ch + 1);
  endfunction

  task automatic set_samples(input int k);
    angle_adc = samp(k, 0);
    currA_adc = samp(k, 1);
    currB_adc = samp(k, 2);
    currC_adc = samp(k, 3);
    currT_req = samp(k, 4);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_steps, output int steps, output bit found);
    found = 1'b0;
    steps = 0;
    while (!found && steps < max_steps) begin
      step(1);
      steps++;
      if (core_valid) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    rstb = 1'b1; enable = 1'b0; period_in = '0; core_ready = 1'b0;
    cfg_req = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0; clear_err = 1'b0;
    set_samples(9);
    step(2);
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_core_valid got %0h expected 0", core_valid); end
    checks++; if ({cfg_ack, pid_d_wen, pid_q_wen} !== 3'b000) begin errors++; $display("FAIL reset_cfg got %0b expected 000", {cfg_ack, pid_d_wen, pid_q_wen}); end
    checks++; if ({pid_d_addr, pid_d_data, pid_q_addr, pid_q_data} !== '0) begin errors++; $display("FAIL reset_pid_bus got nonzero expected 0"); end
    checks++; if ({angle_out, currA_out, currB_out, currC_out, currT_out} !== '0) begin errors++; $display("FAIL reset_samples got nonzero expected 0"); end
    checks++; if ({loop_count, overrun, timeout_err} !== '0) begin errors++; $display("FAIL reset_status got %0h expected 0", {loop_count, overrun, timeout_err}); end
    rstb = 1'b0;
    step(1);
  endtask

  task automatic test_periodic;
    int steps; bit found;
    period_in = CW'(20);
    set_samples(1);
    enable = 1'b1;
    for (int l = 0; l < 3; l++) begin
      wait_valid(30, steps, found);
      checks++; if (!found || steps != ((l == 0) ? 20 : 14)) begin errors++; $display("FAIL periodic_valid_spacing loop %0d got %0d expected %0d", l, steps, (l == 0) ? 20 : 14); end
      checks++; if (angle_out !== samp(l + 1, 0) || currC_out !== samp(l + 1, 3)) begin errors++; $display("FAIL periodic_capture loop %0d got %0h expected %0h", l, angle_out, samp(l + 1, 0)); end
      checks++; if (currT_out !== samp(l + 1, 4)) begin errors++; $display("FAIL periodic_torque loop %0d got %0h expected %0h", l, currT_out, samp(l + 1, 4)); end
      set_samples(l + 2);
      step(1);
      checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL periodic_valid_width got %0h expected 0", core_valid); end
      step(4);
      checks++; if (currA_out !== samp(l + 1, 1)) begin errors++; $display("FAIL periodic_hold_busy got %0h expected %0h", currA_out, samp(l + 1, 1)); end
      core_ready = 1'b1;
      step(1);
      core_ready = 1'b0;
      exp_loops++;
    end
    enable = 1'b0;
    checks++; if (loop_count !== CW'(exp_loops)) begin errors++; $display("FAIL periodic_loop_count got %0d expected %0d", loop_count, exp_loops); end
    step(2);
  endtask

  task automatic test_cfg;
    enable = 1'b0;
    cfg_sel = 1'b0; cfg_addr = DW'(PID_KP_ADDR); cfg_data = DW'(1 << 12); cfg_req = 1'b1;
    step(1);
    checks++; if ({pid_d_wen, pid_q_wen, cfg_ack} !== 3'b101) begin errors++; $display("FAIL cfg_d_strobes got %0b expected 101", {pid_d_wen, pid_q_wen, cfg_ack}); end
    checks++; if (pid_d_addr !== DW'(PID_KP_ADDR) || pid_d_data !== DW'(4096)) begin errors++; $display("FAIL cfg_d_bus got %0h/%0h expected 0/1000", pid_d_addr, pid_d_data); end
    cfg_req = 1'b0;
    step(1);
    checks++; if ({pid_d_wen, cfg_ack} !== 2'b00 || pid_d_data !== '0) begin errors++; $display("FAIL cfg_d_release got %0b/%0h expected 00/0", {pid_d_wen, cfg_ack}, pid_d_data); end
    cfg_sel = 1'b1; cfg_addr = DW'(PID_KI_ADDR); cfg_data = DW'(1 << 9); cfg_req = 1'b1;
    step(1);
    checks++; if ({pid_d_wen, pid_q_wen, cfg_ack} !== 3'b011) begin errors++; $display("FAIL cfg_q_strobes got %0b expected 011", {pid_d_wen, pid_q_wen, cfg_ack}); end
    checks++; if (pid_q_addr !== DW'(PID_KI_ADDR) || pid_q_data !== DW'(512)) begin errors++; $display("FAIL cfg_q_bus got %0h/%0h expected 1/200", pid_q_addr, pid_q_data); end
    cfg_req = 1'b0;
    step(1);
    checks++; if ({pid_q_wen, cfg_ack} !== 2'b00 || pid_q_addr !== '0) begin errors++; $display("FAIL cfg_q_release got %0b/%0h expected 00/0", {pid_q_wen, cfg_ack}, pid_q_addr); end
    step(1);
  endtask

  task automatic test_cfg_vs_tick;
    period_in = CW'(20);
    enable = 1'b1;
    step(19);
    cfg_sel = 1'b0; cfg_addr = DW'(PID_KI_ADDR); cfg_data = DW'(7); cfg_req = 1'b1;
    step(1);
    checks++; if ({core_valid, cfg_ack, pid_d_wen} !== 3'b100) begin errors++; $display("FAIL prio_issue_first got %0b expected 100", {core_valid, cfg_ack, pid_d_wen}); end
    step(3);
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL prio_no_cfg_in_busy got %0h expected 0", cfg_ack); end
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    exp_loops++;
    step(1);
    checks++; if ({cfg_ack, pid_d_wen} !== 2'b11 || pid_d_data !== DW'(7)) begin errors++; $display("FAIL prio_cfg_after_loop got %0b/%0h expected 11/7", {cfg_ack, pid_d_wen}, pid_d_data); end
    checks++; if (loop_count !== CW'(exp_loops)) begin errors++; $display("FAIL prio_loop_count got %0d expected %0d", loop_count, exp_loops); end
    cfg_req = 1'b0;
    enable = 1'b0;
    step(2);
  endtask

  task automatic test_overrun;
    int steps; bit found;
    period_in = CW'(10);
    enable = 1'b1;
    step(10);
    checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %0h expected 1", core_valid); end
    step(10);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_single_pending got %0h expected 0", overrun); end
    step(10);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_second_tick got %0h expected 1", overrun); end
    enable = 1'b0;
    step(5);
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    exp_loops++;
    wait_valid(5, steps, found);
    checks++; if (!found || steps != 1) begin errors++; $display("FAIL ovr_pending_serviced got %0d expected 1", steps); end
    step(1);
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    exp_loops++;
    checks++; if (overrun !== 1'b1 || loop_count !== CW'(exp_loops)) begin errors++; $display("FAIL ovr_sticky got %0h/%0d expected 1/%0d", overrun, loop_count, exp_loops); end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0h expected 0", overrun); end
    step(2);
  endtask

  task automatic test_timeout;
    int steps; bit found;
    period_in = CW'(20);
    enable = 1'b1;
    wait_valid(25, steps, found);
    checks++; if (!found || steps != 20) begin errors++; $display("FAIL to_valid got %0d expected 20", steps); end
    enable = 1'b0;
    step(1024);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %0h expected 0", timeout_err); end
    step(1);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire got %0h expected 1", timeout_err); end
    checks++; if (loop_count !== CW'(exp_loops) || overrun !== 1'b0) begin errors++; $display("FAIL to_status got %0d/%0h expected %0d/0", loop_count, overrun, exp_loops); end
    enable = 1'b1;
    wait_valid(25, steps, found);
    checks++; if (!found || steps != 20) begin errors++; $display("FAIL to_next_issue got %0d expected 20", steps); end
    enable = 1'b0;
    step(1);
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    exp_loops++;
    checks++; if (loop_count !== CW'(exp_loops) || timeout_err !== 1'b1) begin errors++; $display("FAIL to_recover got %0d/%0h expected %0d/1", loop_count, timeout_err, exp_loops); end
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %0h expected 0", timeout_err); end
    step(2);
  endtask

  task automatic test_min_period;
    int steps; bit found;
    for (int p = 0; p < 2; p++) begin
      period_in = CW'(p);
      enable = 1'b1;
      wait_valid(6, steps, found);
      checks++; if (!found || steps != 2) begin errors++; $display("FAIL min_period_%0d got %0d expected 2", p, steps); end
      enable = 1'b0;
      step(1);
      core_ready = 1'b1;
      step(1);
      core_ready = 1'b0;
      exp_loops++;
      step(2);
    end
    checks++; if (loop_count !== CW'(exp_loops)) begin errors++; $display("FAIL min_period_loops got %0d expected %0d", loop_count, exp_loops); end
  endtask

  task automatic test_reset_mid;
    int steps; bit found;
    period_in = CW'(20);
    set_samples(5);
    enable = 1'b1;
    wait_valid(25, steps, found);
    checks++; if (!found || steps != 20) begin errors++; $display("FAIL rst_pre_valid got %0d expected 20", steps); end
    step(3);
    rstb = 1'b1;
    #1;
    checks++; if ({angle_out, currT_out} !== '0 || loop_count !== '0) begin errors++; $display("FAIL rst_async_clear got %0h/%0d expected 0/0", angle_out, loop_count); end
    checks++; if ({core_valid, cfg_ack, overrun, timeout_err} !== 4'b0000) begin errors++; $display("FAIL rst_async_flags got %0b expected 0000", {core_valid, cfg_ack, overrun, timeout_err}); end
    exp_loops = 0;
    @(negedge clk);
    rstb = 1'b0;
    wait_valid(25, steps, found);
    checks++; if (!found || steps != 20) begin errors++; $display("FAIL rst_post_valid got %0d expected 20", steps); end
    checks++; if (angle_out !== samp(5, 0)) begin errors++; $display("FAIL rst_post_capture got %0h expected %0h", angle_out, samp(5, 0)); end
    enable = 1'b0;
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    step(2);
    checks++; if (loop_count !== CW'(0)) begin errors++; $display("FAIL stale_ready_ignored got %0d expected 0", loop_count); end
    core_ready = 1'b1;
    step(1);
    core_ready = 1'b0;
    checks++; if (loop_count !== CW'(1)) begin errors++; $display("FAIL stale_then_ready got %0d expected 1", loop_count); end
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset;
    test_periodic;
    test_cfg;
    test_cfg_vs_tick;
    test_overrun;
    test_timeout;
    test_min_period;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/foc_loop_sched.md
Name: foc_loop_sched

Overview:
Sequencer for the FOC current-loop core (top).
- Generates the periodic loop trigger.
- Captures angle, phase-current and torque-request samples into held registers.
- Issues a single-cycle valid to the core and waits for its ready, with a watchdog.
- Shares the core's PID coefficient write ports with a host config interface, granting writes only while the core is idle.

Parameters:
D_WIDTH, 19, width of angle, current, torque, PID address and data buses
Q_BITS, 15, fractional bits of fixed-point samples (pass-through, no arithmetic)
CNT_WIDTH, 16, width of period counter and loop counter
TIMEOUT, 1024, max clk cycles in BUSY before watchdog error

Ports:
clk  in  1  clock
rstb  in  1  reset, asynchronous, active-high
enable  in  1  run periodic loop
period_in  in  CNT_WIDTH  loop period in clk cycles; values <2 treated as 2
angle_adc  in  D_WIDTH  resolver angle sample
currA_adc, currB_adc, currC_adc  in  D_WIDTH  phase current samples
currT_req  in  D_WIDTH  signed target current from ECU
angle_out, currA_out, currB_out, currC_out, currT_out  out  D_WIDTH  held samples to core
core_valid  out  1  one-cycle start pulse to core
core_ready  in  1  core done
cfg_req  in  1  host coefficient write request (level, held until cfg_ack)
cfg_sel  in  1  0 = d-axis PID, 1 = q-axis PID
cfg_addr, cfg_data  in  D_WIDTH  coefficient address and value
cfg_ack  out  1  one-cycle pulse: write issued
pid_d_wen, pid_q_wen  out  1  coefficient write enables to core
pid_d_addr, pid_q_addr, pid_d_data, pid_q_data  out  D_WIDTH  coefficient write bus
clear_err  in  1  clears sticky errors
overrun  out  1  sticky: tick dropped
timeout_err  out  1  sticky: watchdog fired
loop_count  out  CNT_WIDTH  completed loops, wraps

Behaviour:
- Reset: state IDLE; all outputs, counters, pending_tick and errors = 0. Reset mid-loop aborts the loop with no core_valid and no cfg_ack afterwards.
- Period counter:
  - enable=0: held at 0, no ticks.
  - enable=1: counts 0..P-1, where P = max(period_in, 2), sampled when the counter is 0.
  - tick asserted in the cycle where count == P-1.
- pending_tick:
  - Set by a tick in any state other than IDLE.
  - Cleared on entering ISSUE.
  - A tick while pending_tick is already 1 sets overrun; that tick is dropped.
- States:
  - IDLE:
    - If tick or pending_tick: go to ISSUE and capture all *_adc and currT_req into *_out on that edge.
    - Else if cfg_req: go to CFG.
    - Loop triggers take priority over config.
  - CFG (1 cycle):
    - pid_d_wen (cfg_sel=0) or pid_q_wen (cfg_sel=1) = 1, with the matching addr/data driven from cfg_addr/cfg_data.
    - cfg_ack = 1.
    - Next state IDLE.
    - The non-selected wen stays 0; addr/data buses are 0 when not in CFG.
  - ISSUE (1 cycle): core_valid = 1; next state BUSY; watchdog cleared.
  - BUSY:
    - core_ready=1: loop_count+1, go to IDLE.
    - Else watchdog+1; at watchdog == TIMEOUT-1 with no ready, set timeout_err and go to IDLE.
    - core_ready is ignored in ISSUE, so a stale ready cannot complete a loop.
- Latency: tick cycle n, core_valid high in cycle n+1, samples stable from n+1 until the next ISSUE.
- *_out are never modified in CFG or BUSY.
- enable deasserted mid-loop: the current loop completes; pending_tick is kept and serviced.
- clear_err=1 clears overrun and timeout_err. If clear_err coincides with a set event, the set wins.
- All outputs registered; no arithmetic beyond counters; counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Package foc_pkg:
  - state enum (IDLE, CFG, ISSUE, BUSY)
  - D_WIDTH/Q_BITS defaults
  - PID coefficient address constants: KP = 0, KI = 1
- Sub-module loop_timer (period counter and tick generation); FSM and arbitration stay in the top of this block.

Test Plan:
- enable=1, period_in=20, core_ready pulsed 5 cycles after each valid → core_valid every 20 cycles, 1 cycle after tick; loop_count=3 after 3 loops; *_out equal to samples at the tick edge.
- cfg_req with cfg_sel=0, addr=0, data=1<<12, then cfg_sel=1, addr=1, data=1<<9, enable=0 → one pid_d_wen then one pid_q_wen pulse with the correct addr/data; cfg_ack once each; the other wen stays 0.
- cfg_req asserted in the same cycle as tick → ISSUE first, CFG only after core_ready returns the FSM to IDLE.
- period_in=10, core_ready delayed 25 cycles → overrun=1 after the second tick during BUSY; clear_err → overrun=0.
- core_ready held 0 with TIMEOUT=1024 → timeout_err=1 exactly 1024 cycles after entering BUSY; FSM returns to IDLE; the next tick issues normally.
- rstb pulsed during BUSY → all outputs 0 on assertion; with enable=1 the next core_valid follows P cycles after release.
